motor_btn_conditioner: RTL

//  Upstream input stage for the DC-motor PWM controller. Synchronises and

---
 rtl/motor_btn_conditioner.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/motor_btn_conditioner.sv
// motor_btn_conditioner
// Input stage for the DC-motor PWM controller: synchronises and debounces the
// raw inc/dec push-buttons and turns debounced presses into single-cycle step
// pulses for the duty-cycle FSM. Pressing both buttons locks out stepping.
// Optional feature macro: BTN_REPEAT_EN enables hold-to-repeat (HOLD -> REPEAT
// auto-stepping). Without it, each debounced press yields exactly one step.
module motor_btn_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_raw,
  input  logic dec_raw,
  output logic inc_level,
  output logic dec_level,
  output logic inc_step,
  output logic dec_step,
  output logic lock
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  // Channel index 0 is inc, 1 is dec throughout.
  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] dec_sync;
  logic [1:0]             s_btn;
  logic [1:0]             level;
  logic [1:0][DB_W-1:0]   cnt;

  state_t state, state_nxt;
  logic   sel, sel_nxt;
  logic   inc_step_nxt, dec_step_nxt;
  logic   held_lvl, other_lvl;

  // Synchroniser chains: shift raw button levels into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_sync <= '0;
      dec_sync <= '0;
    end else begin
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], inc_raw};
      dec_sync <= {dec_sync[SYNC_STAGES-2:0], dec_raw};
    end
  end

  assign s_btn = {dec_sync[SYNC_STAGES-1], inc_sync[SYNC_STAGES-1]};

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      cnt   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_btn[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign inc_level = level[0];
  assign dec_level = level[1];
  assign lock      = level[0] & level[1];

  // Level of the channel being held, and of the opposite channel.
  assign held_lvl  = sel ? level[1] : level[0];
  assign other_lvl = sel ? level[0] : level[1];

`ifdef BTN_REPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // The timer counts down through zero inclusive, so N cycles needs a load of N-1.
  localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

  logic [TMR_W-1:0] timer, timer_nxt;
`else
  // Repeat timing has no effect when auto-repeat is not built.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Step FSM next-state: IDLE only ever holds with both levels low, so a high
  // level seen in IDLE is a fresh press.
  always_comb begin
    logic pulse;
    pulse     = 1'b0;
    state_nxt = state;
    sel_nxt   = sel;
`ifdef BTN_REPEAT_EN
    timer_nxt = timer;
`endif
    case (state)
      IDLE: begin
        if (level[0] && level[1]) begin
          state_nxt = LOCK;
        end else if (level[0] || level[1]) begin
          state_nxt = HOLD;
          sel_nxt   = level[1];
          pulse     = 1'b1;
`ifdef BTN_REPEAT_EN
          timer_nxt = DELAY_LOAD;
`endif
        end
      end
      HOLD, REPEAT: begin
        if (other_lvl) begin
          state_nxt = LOCK;
        end else if (!held_lvl) begin
          state_nxt = IDLE;
        end else begin
`ifdef BTN_REPEAT_EN
          if (timer == '0) begin
            pulse     = 1'b1;
            state_nxt = REPEAT;
            timer_nxt = PERIOD_LOAD;
          end else begin
            timer_nxt = timer - 1'b1;
          end
`endif
        end
      end
      LOCK: begin
        if (!level[0] && !level[1]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    inc_step_nxt = pulse && !sel_nxt;
    dec_step_nxt = pulse && sel_nxt;
  end

  // Step FSM registers; step outputs are registered straight from the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      inc_step <= 1'b0;
      dec_step <= 1'b0;
`ifdef BTN_REPEAT_EN
      timer    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      inc_step <= inc_step_nxt;
      dec_step <= dec_step_nxt;
`ifdef BTN_REPEAT_EN
      timer    <= timer_nxt;
`endif
    end
  end

endmodule
